rr_arbiter: RTL and testbench



---
 rtl/rr_arbiter.sv | 143 ++++++++++++++
 tb/tb_rr_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: rotating-priority one-hot grant over NumReq valid/ready sources into a
// one-entry output register. Define RR_ARBITER_BURST_LOCK_EN to hold the grant across multi-beat bursts.
//
// state   | meaning
// ST_ARB  | free arbitration, priority starts at ptr_q
// ST_LOCK | grant pinned to lock_id_q until its last beat is accepted
module rr_arbiter #(
   parameter int NumReq    = 4,
   parameter int DataWidth = 8,
   parameter int IdWidth   = $clog2(NumReq)
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic [NumReq-1:0]                valid_i,
   input  logic [NumReq-1:0][DataWidth-1:0] data_i,
   input  logic [NumReq-1:0]                last_i,
   output logic [NumReq-1:0]                ready_o,
   output logic                             valid_o,
   output logic [DataWidth-1:0]             data_o,
   output logic                             last_o,
   output logic [IdWidth-1:0]               id_o,
   input  logic                             ready_i
);

   logic [IdWidth-1:0]   ptr_q, ptr_d;
   logic [NumReq-1:0]    prio_mask, mreq;
   logic [IdWidth-1:0]   arb_idx, gnt_idx;
   logic                 gnt_any, can_accept, hs, upd_ptr;
   logic                 valid_q, valid_d, last_q, last_d;
   logic [DataWidth-1:0] data_q, data_d;
   logic [IdWidth-1:0]   id_q, id_d;

   assign can_accept = ~valid_q | ready_i;

   // Lowest set bit of the masked request wins; fall back to the unmasked scan on wrap.
   always_comb begin
      prio_mask = '0;
      for (int i = 0; i < NumReq; i++) begin
         prio_mask[i] = (i >= int'(ptr_q));
      end
      mreq    = valid_i & prio_mask;
      arb_idx = '0;
      for (int i = NumReq - 1; i >= 0; i--) begin
         if (valid_i[i]) arb_idx = IdWidth'(i);
      end
      for (int i = NumReq - 1; i >= 0; i--) begin
         if (mreq[i]) arb_idx = IdWidth'(i);
      end
   end

`ifdef RR_ARBITER_BURST_LOCK_EN
   typedef enum logic {ST_ARB, ST_LOCK} state_e;

   state_e             state_q, state_d;
   logic [IdWidth-1:0] lock_id_q, lock_id_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_ARB;
         lock_id_q <= '0;
      end else begin
         state_q   <= state_d;
         lock_id_q <= lock_id_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      lock_id_d = lock_id_q;
      gnt_idx   = arb_idx;
      gnt_any   = |valid_i;
      upd_ptr   = 1'b0;
      if (state_q == ST_LOCK) begin
         gnt_idx = lock_id_q;
         gnt_any = valid_i[lock_id_q];
      end
      hs = gnt_any & can_accept;
      if (hs) begin
         if (last_i[gnt_idx]) begin
            state_d = ST_ARB;
            upd_ptr = 1'b1;
         end else begin
            state_d   = ST_LOCK;
            lock_id_d = gnt_idx;
         end
      end
   end
`else
   always_comb begin
      gnt_idx = arb_idx;
      gnt_any = |valid_i;
      hs      = gnt_any & can_accept;
      upd_ptr = hs;
   end
`endif

   always_comb begin
      ready_o = '0;
      if (hs) ready_o[gnt_idx] = 1'b1;
   end

   always_comb begin
      ptr_d = ptr_q;
      if (upd_ptr) begin
         ptr_d = (gnt_idx == IdWidth'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   // Drain and load can happen in the same cycle, giving one beat per clock.
   always_comb begin
      valid_d = hs | (valid_q & ~ready_i);
      data_d  = data_q;
      last_d  = last_q;
      id_d    = id_q;
      if (hs) begin
         data_d = data_i[gnt_idx];
         last_d = last_i[gnt_idx];
         id_d   = gnt_idx;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
         id_q    <= '0;
      end else begin
         ptr_q   <= ptr_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
         id_q    <= id_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign last_o  = last_q;
   assign id_o    = id_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter (NumReq=4, DataWidth=8); expected beats are queued as
// stimulus is set up and popped whenever the output register is drained.
module tb_rr_arbiter;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int IW = 2;

   typedef struct packed {
      logic [IW-1:0] id;
      logic [DW-1:0] dat;
      logic          lst;
   } beat_t;

   logic                  clk_i = 1'b0;
   logic                  rst_i;
   logic [NR-1:0]         valid_i;
   logic [NR-1:0][DW-1:0] data_i;
   logic [NR-1:0]         last_i;
   logic [NR-1:0]         ready_o;
   logic                  valid_o;
   logic [DW-1:0]         data_o;
   logic                  last_o;
   logic [IW-1:0]         id_o;
   logic                  ready_i;

   int    n_vec = 0;
   int    n_err = 0;
   beat_t sbq[$];

   logic [DW-1:0] src_dat[NR][4];
   logic          src_lst[NR][4];
   int            src_n[NR];
   int            src_rd[NR];
   logic [NR-1:0] hold;
   logic [NR-1:0] g;

   rr_arbiter #(.NumReq(NR), .DataWidth(DW)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .valid_i (valid_i),
      .data_i  (data_i),
      .last_i  (last_i),
      .ready_o (ready_o),
      .valid_o (valid_o),
      .data_o  (data_o),
      .last_o  (last_o),
      .id_o    (id_o),
      .ready_i (ready_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic exp_beat(input int id, input int dat, input bit lst);
      beat_t b;
      b.id  = IW'(id);
      b.dat = DW'(dat);
      b.lst = lst;
      sbq.push_back(b);
   endtask

   task automatic src_clear();
      for (int k = 0; k < NR; k++) begin
         src_n[k]  = 0;
         src_rd[k] = 0;
      end
   endtask

   task automatic src_add(input int k, input int dat, input bit lst);
      src_dat[k][src_n[k]] = DW'(dat);
      src_lst[k][src_n[k]] = lst;
      src_n[k]++;
   endtask

   // One cycle: present each source's head beat, sample grants before the edge, retire on grant.
   task automatic step(output logic [NR-1:0] gnt);
      for (int k = 0; k < NR; k++) begin
         if (src_rd[k] < src_n[k] && !hold[k]) begin
            valid_i[k] = 1'b1;
            data_i[k]  = src_dat[k][src_rd[k]];
            last_i[k]  = src_lst[k][src_rd[k]];
         end else begin
            valid_i[k] = 1'b0;
            data_i[k]  = '0;
            last_i[k]  = 1'b0;
         end
      end
      #1 gnt = ready_o;
      @(posedge clk_i);
      #1;
      for (int k = 0; k < NR; k++) begin
         if (gnt[k]) src_rd[k]++;
      end
   endtask

   always @(negedge clk_i) begin
      beat_t e;
      if (!rst_i && valid_o && ready_i) begin
         if (sbq.size() == 0) begin
            chk("sb_extra_beat", 32'(valid_o), 32'd0);
         end else begin
            e = sbq.pop_front();
            chk("sb_id", 32'(id_o), 32'(e.id));
            chk("sb_data", 32'(data_o), 32'(e.dat));
            chk("sb_last", 32'(last_o), 32'(e.lst));
         end
      end
   end

   initial begin
      rst_i   = 1'b1;
      valid_i = '0;
      data_i  = '0;
      last_i  = '0;
      ready_i = 1'b0;
      hold    = '0;
      src_clear();
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_data", 32'(data_o), 32'd0);
      chk("rst_last", 32'(last_o), 32'd0);
      chk("rst_id", 32'(id_o), 32'd0);
      chk("rst_ready", 32'(ready_o), 32'd0);
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;

      // Fairness: everyone requesting, grants rotate 0,1,2,3 then wrap to 0.
      src_clear();
      for (int k = 0; k < NR; k++) begin
         src_add(k, 'h10 + k, 1'b1);
         src_add(k, 'h18 + k, 1'b1);
      end
      ready_i = 1'b1;
      exp_beat(0, 'h10, 1); exp_beat(1, 'h11, 1); exp_beat(2, 'h12, 1);
      exp_beat(3, 'h13, 1); exp_beat(0, 'h18, 1);
      for (int c = 0; c < 5; c++) begin
         step(g);
         chk("fair_valid", 32'(valid_o), 32'd1);
      end
      for (int k = 0; k < NR; k++) src_n[k] = src_rd[k];
      step(g);
      chk("fair_drained", 32'(valid_o), 32'd0);

      // Skip/wrap: ptr=1 with requesters 0 and 3 -> 3, then 0.
      src_clear();
      src_add(0, 'h50, 1'b1);
      src_add(3, 'h53, 1'b1);
      exp_beat(3, 'h53, 1); exp_beat(0, 'h50, 1);
      step(g);
      chk("skip_gnt", 32'(g), 32'h8);
      step(g);
      chk("wrap_gnt", 32'(g), 32'h1);
      step(g);

      // Backpressure: hold 0xA5 three cycles, then drain and load the next beat together.
      src_clear();
      src_add(1, 'hA5, 1'b1);
      src_add(1, 'h5A, 1'b1);
      exp_beat(1, 'hA5, 1); exp_beat(1, 'h5A, 1);
      ready_i = 1'b0;
      step(g);
      chk("bp_first_gnt", 32'(g), 32'h2);
      for (int c = 0; c < 3; c++) begin
         step(g);
         chk("bp_stall_rdy", 32'(g), 32'h0);
         chk("bp_stall_data", 32'(data_o), 32'hA5);
         chk("bp_stall_valid", 32'(valid_o), 32'd1);
      end
      ready_i = 1'b1;
      step(g);
      chk("bp_resume_gnt", 32'(g), 32'h2);
      chk("bp_resume_data", 32'(data_o), 32'h5A);
      ready_i = 1'b0;
      step(g);

      // Asynchronous reset in mid-cycle with a beat held.
      #3 rst_i = 1'b1;
      sbq.delete();
      #1;
      chk("arst_valid", 32'(valid_o), 32'd0);
      chk("arst_data", 32'(data_o), 32'd0);
      chk("arst_last", 32'(last_o), 32'd0);
      chk("arst_id", 32'(id_o), 32'd0);
      chk("arst_ready", 32'(ready_o), 32'd0);
      @(posedge clk_i);
      #1 rst_i = 1'b0;

      // Burst A: requester 1 sends three beats while requester 2 waits with two.
      src_clear();
      src_add(1, 'h11, 1'b0); src_add(1, 'h12, 1'b0); src_add(1, 'h13, 1'b1);
      src_add(2, 'h21, 1'b1); src_add(2, 'h22, 1'b1);
      ready_i = 1'b1;
`ifdef RR_ARBITER_BURST_LOCK_EN
      exp_beat(1, 'h11, 0); exp_beat(1, 'h12, 0); exp_beat(1, 'h13, 1);
      exp_beat(2, 'h21, 1); exp_beat(2, 'h22, 1);
`else
      exp_beat(1, 'h11, 0); exp_beat(2, 'h21, 1); exp_beat(1, 'h12, 0);
      exp_beat(2, 'h22, 1); exp_beat(1, 'h13, 1);
`endif
      for (int c = 0; c < 5; c++) begin
         step(g);
         chk("burst_valid", 32'(valid_o), 32'd1);
      end
      step(g);

      rst_i = 1'b1;
      @(posedge clk_i);
      #1 rst_i = 1'b0;

      // Burst B: requester 1 drops valid for two cycles after its first beat.
      src_clear();
      src_add(1, 'h31, 1'b0); src_add(1, 'h32, 1'b0); src_add(1, 'h33, 1'b1);
      src_add(2, 'h41, 1'b1);
`ifdef RR_ARBITER_BURST_LOCK_EN
      exp_beat(1, 'h31, 0); exp_beat(1, 'h32, 0); exp_beat(1, 'h33, 1); exp_beat(2, 'h41, 1);
`else
      exp_beat(1, 'h31, 0); exp_beat(2, 'h41, 1); exp_beat(1, 'h32, 0); exp_beat(1, 'h33, 1);
`endif
      step(g);
      chk("gap_first_gnt", 32'(g), 32'h2);
      hold = 4'b0010;
      step(g);
`ifdef RR_ARBITER_BURST_LOCK_EN
      chk("gap_gnt1", 32'(g), 32'h0);
`else
      chk("gap_gnt1", 32'(g), 32'h4);
`endif
      step(g);
      chk("gap_gnt2", 32'(g), 32'h0);
      hold = '0;
      for (int c = 0; c < 4; c++) step(g);
      chk("gap_drained", 32'(valid_o), 32'd0);

      chk("sb_leftover", 32'(sbq.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
